// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: datapath width and FSM encodings.
package fetch_sequencer_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increment events, holding at the maximum value once reached
  always_ff @(posedge clk) begin
    if (!rst_n)                  count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: picks the next PC (sequential / hold / redirect),
// drives IF/ID and ID/EX controls, and handles boot, halt, watchdog, counters.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
  parameter int              BOOT_CYCLES   = 2,
  parameter int              STALL_TIMEOUT = 16,
  parameter int              CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  fetch_pc_i,
  input  logic [XLEN-1:0]  fetch_pcPlus4_i,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             halted_o,
  output logic             wdog_err_o,
  output logic             misalign_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int SW = $clog2(STALL_TIMEOUT);

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] boot_cnt;
  logic [SW-1:0] stall_run;
  logic          stall_inc, flush_inc, set_mis, set_wdog;

  // Next-PC mux, pipeline controls and next state; reset forces the boot outputs
  always_comb begin
    pc_o          = RESET_PC;
    if_id_en_o    = 1'b0;
    if_id_flush_o = 1'b1;
    id_ex_flush_o = 1'b1;
    state_nxt     = state;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    set_mis       = 1'b0;
    set_wdog      = 1'b0;
    if (rst_n) begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BW'(BOOT_CYCLES - 1)) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid_i) begin
            // redirect wins over a same-cycle stall; the stall is dropped
            pc_o       = redirect_pc_i;
            if_id_en_o = 1'b1;
            flush_inc  = 1'b1;
            if (redirect_pc_i[1:0] != 2'b00) begin
              set_mis   = 1'b1;
              state_nxt = ST_HALT;
            end
          end else if (stall_i) begin
            pc_o          = fetch_pc_i;
            if_id_flush_o = 1'b0;
            stall_inc     = 1'b1;
            if (stall_run == SW'(STALL_TIMEOUT - 1)) begin
              set_wdog  = 1'b1;
              state_nxt = ST_HALT;
            end
          end else begin
            pc_o          = fetch_pcPlus4_i;
            if_id_en_o    = 1'b1;
            if_id_flush_o = 1'b0;
            id_ex_flush_o = 1'b0;
          end
          if (halt_i) state_nxt = ST_HALT;
        end
        ST_HALT: begin
          pc_o          = fetch_pc_i;
          if_id_flush_o = 1'b0;
          if (resume_i && !halt_i) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_BOOT;
      endcase
    end
  end

  // FSM state, boot timer, consecutive-stall run length and sticky errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_BOOT;
      boot_cnt       <= '0;
      stall_run      <= '0;
      wdog_err_o     <= 1'b0;
      misalign_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (state == ST_BOOT) boot_cnt <= boot_cnt + BW'(1);
      stall_run <= stall_inc ? stall_run + SW'(1) : '0;
      if (set_wdog) wdog_err_o     <= 1'b1;
      if (set_mis)  misalign_err_o <= 1'b1;
    end
  end

  assign halted_o = (state == ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the bench owns a model fetch register.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc, fetch_pc4;
  logic        stall, redir, halt, resume;
  logic [31:0] redir_pc;
  logic [31:0] pc;
  logic        en, ifl, idfl, halted, wdog, mis;
  logic [31:0] scnt, fcnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // fetch stage register: loads the sequencer's PC every edge
  always @(posedge clk) fetch_pc <= pc;
  assign fetch_pc4 = fetch_pc + 32'd4;

  fetch_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_pc_i       (fetch_pc),
    .fetch_pcPlus4_i  (fetch_pc4),
    .stall_i          (stall),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .halt_i           (halt),
    .resume_i         (resume),
    .pc_o             (pc),
    .if_id_en_o       (en),
    .if_id_flush_o    (ifl),
    .id_ex_flush_o    (idfl),
    .halted_o         (halted),
    .wdog_err_o       (wdog),
    .misalign_err_o   (mis),
    .stall_cnt_o      (scnt),
    .flush_cnt_o      (fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ctl(input string tag, input logic [31:0] epc, input logic een,
                     input logic eifl, input logic eidfl);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".en"}, {31'd0, en}, {31'd0, een});
    chk({tag, ".ifl"}, {31'd0, ifl}, {31'd0, eifl});
    chk({tag, ".idfl"}, {31'd0, idfl}, {31'd0, eidfl});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b1; redir = 1'b1; redir_pc = 32'h40; halt = 1'b0; resume = 1'b0;
    #1;
    ctl("reset_force", 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    chk("reset.halted", {31'd0, halted}, 32'd0);
    chk("reset.scnt", scnt, 32'd0);
    chk("reset.fcnt", fcnt, 32'd0);
    chk("reset.wdog", {31'd0, wdog}, 32'd0);
    chk("reset.mis", {31'd0, mis}, 32'd0);

    // boot: two cycles of RESET_PC with flushes, inputs ignored
    rst_n = 1'b1; #1;
    ctl("boot1", 32'h0, 1'b0, 1'b1, 1'b1);
    tick(); #1;
    ctl("boot2", 32'h0, 1'b0, 1'b1, 1'b1);
    stall = 1'b0; redir = 1'b0;
    tick(); #1; ctl("run4", 32'h4, 1'b1, 1'b0, 1'b0);
    tick(); #1; chk("run8", pc, 32'h8);
    tick(); #1; chk("runC", pc, 32'hC);
    tick(); #1; chk("run10", pc, 32'h10);

    // two-cycle stall at 0x10
    tick(); stall = 1'b1; #1; ctl("stall1", 32'h10, 1'b0, 1'b0, 1'b1);
    tick(); #1; ctl("stall2", 32'h10, 1'b0, 1'b0, 1'b1);
    tick(); stall = 1'b0; #1;
    ctl("post_stall", 32'h14, 1'b1, 1'b0, 1'b0);
    chk("post_stall.scnt", scnt, 32'd2);

    // redirect with simultaneous stall
    tick(); stall = 1'b1; redir = 1'b1; redir_pc = 32'h80; #1;
    ctl("redir80", 32'h80, 1'b1, 1'b1, 1'b1);
    tick(); stall = 1'b0; redir = 1'b0; #1;
    chk("post_redir.pc", pc, 32'h84);
    chk("post_redir.fcnt", fcnt, 32'd1);
    chk("post_redir.scnt", scnt, 32'd2);

    // misaligned redirect -> HALT, redirect/stall ignored while halted
    tick(); redir = 1'b1; redir_pc = 32'h82; #1;
    chk("mis.pc", pc, 32'h82);
    tick(); redir_pc = 32'h200; stall = 1'b1; #1;
    chk("mis.err", {31'd0, mis}, 32'd1);
    chk("mis.halted", {31'd0, halted}, 32'd1);
    ctl("halt_hold", 32'h82, 1'b0, 1'b0, 1'b1);
    tick(); redir = 1'b0; stall = 1'b0; resume = 1'b1; #1;
    chk("halt_ign.fcnt", fcnt, 32'd2);
    chk("halt_ign.scnt", scnt, 32'd2);
    chk("halt_resume.pc", pc, 32'h82);
    tick(); resume = 1'b0; #1;
    chk("resumed.halted", {31'd0, halted}, 32'd0);
    chk("resumed.mis", {31'd0, mis}, 32'd1);
    chk("resumed.pc", pc, 32'h86);

    // realign, then 15 stalls: below watchdog threshold
    tick(); redir = 1'b1; redir_pc = 32'h100; #1;
    chk("realign.pc", pc, 32'h100);
    tick(); redir = 1'b0; stall = 1'b1;
    repeat (15) tick();
    stall = 1'b0; #1;
    chk("st15.wdog", {31'd0, wdog}, 32'd0);
    chk("st15.halted", {31'd0, halted}, 32'd0);
    chk("st15.scnt", scnt, 32'd17);
    chk("st15.pc", pc, 32'h104);

    // 16 stalls: watchdog trips
    tick(); stall = 1'b1;
    repeat (16) tick();
    stall = 1'b0; #1;
    chk("st16.wdog", {31'd0, wdog}, 32'd1);
    chk("st16.halted", {31'd0, halted}, 32'd1);
    chk("st16.scnt", scnt, 32'd33);
    chk("st16.pc", pc, 32'h104);

    // resume blocked by a concurrent halt request
    halt = 1'b1; resume = 1'b1;
    tick(); halt = 1'b0; resume = 1'b0; #1;
    chk("halt_resume_blk", {31'd0, halted}, 32'd1);

    // reset during HALT
    rst_n = 1'b0; #1;
    ctl("rst_halt", 32'h0, 1'b0, 1'b1, 1'b1);
    tick(); rst_n = 1'b1; #1;
    chk("rst_halt.halted", {31'd0, halted}, 32'd0);
    chk("rst_halt.wdog", {31'd0, wdog}, 32'd0);
    chk("rst_halt.mis", {31'd0, mis}, 32'd0);
    chk("rst_halt.scnt", scnt, 32'd0);
    chk("rst_halt.fcnt", fcnt, 32'd0);
    ctl("reboot1", 32'h0, 1'b0, 1'b1, 1'b1);
    tick(); #1; chk("reboot2", pc, 32'h0);

    // halt request in RUN completes the cycle's advance, then halts
    tick(); halt = 1'b1; #1;
    ctl("halt_req", 32'h4, 1'b1, 1'b0, 1'b0);
    tick(); halt = 1'b0; #1;
    chk("halt_req.halted", {31'd0, halted}, 32'd1);
    chk("halt_req.pc", pc, 32'h4);
    resume = 1'b1;
    tick(); resume = 1'b0; #1;
    chk("halt_req.resumed", {31'd0, halted}, 32'd0);
    chk("halt_req.pc8", pc, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block that sequences the fetch stage. The fetch stage register loads its PC input unconditionally on every clock edge. This block drives that input each cycle with the sequential, held (stall) or redirected PC, and issues enable/flush controls to the IF/ID and ID/EX pipeline registers. It also provides boot sequencing, halt/resume, a stall watchdog and saturating performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC driven during reset and boot
BOOT_CYCLES, 2, cycles after reset release with PC held at RESET_PC and pipeline flushed (>=1)
STALL_TIMEOUT, 16, consecutive stall cycles that trip the watchdog (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
fetch_pc_i  in  32  PC currently held in fetch stage
fetch_pcPlus4_i  in  32  fetch_pc_i + 4 from fetch stage
stall_i  in  1  load-use hazard from decode
redirect_valid_i  in  1  taken branch/jump resolved in execute
redirect_pc_i  in  32  redirect target
halt_i  in  1  halt request (ebreak/debug)
resume_i  in  1  leave HALT
pc_o  out  32  next PC, wired to fetch pc_i
if_id_en_o  out  1  IF/ID register load enable
if_id_flush_o  out  1  IF/ID insert bubble
id_ex_flush_o  out  1  ID/EX insert bubble
halted_o  out  1  state == HALT
wdog_err_o  out  1  sticky stall-watchdog error
misalign_err_o  out  1  sticky misaligned-redirect error
stall_cnt_o  out  CNT_W  saturating stall-cycle count
flush_cnt_o  out  CNT_W  saturating redirect count

Behaviour:
- Reset is synchronous, active-low. While rst_n==0, outputs are combinationally forced: pc_o=RESET_PC (so fetch loads RESET_PC on the reset edge), if_id_en_o=0, both flushes=1. At that edge: state<=BOOT, boot_cnt<=0, stall_run<=0, sticky errors<=0, counters<=0.
- States: BOOT, RUN, HALT.
- BOOT:
  - pc_o=RESET_PC, if_id_en_o=0, both flushes=1.
  - boot_cnt increments each cycle; at boot_cnt==BOOT_CYCLES-1, next state is RUN.
  - Inputs are ignored.
- RUN, evaluated by priority, all combinational (zero-latency control):
  1. redirect_valid_i: pc_o=redirect_pc_i, if_id_en_o=1, if_id_flush_o=1, id_ex_flush_o=1; flush_cnt+1. A simultaneous stall_i is ignored and not counted. If redirect_pc_i[1:0]!=0, set misalign_err_o, still apply the redirect, next state is HALT.
  2. stall_i: pc_o=fetch_pc_i (hold), if_id_en_o=0, id_ex_flush_o=1, if_id_flush_o=0; stall_cnt+1; stall_run+1.
  3. Otherwise: pc_o=fetch_pcPlus4_i, if_id_en_o=1, no flush.
  - stall_run clears on any non-stall cycle.
  - If stall_i is high while stall_run==STALL_TIMEOUT-1: set wdog_err_o, next state is HALT.
  - halt_i (with or without a same-cycle redirect): the cycle's PC action completes as above, then next state is HALT.
- HALT:
  - pc_o=fetch_pc_i, if_id_en_o=0, id_ex_flush_o=1, if_id_flush_o=0.
  - redirect_valid_i and stall_i are ignored and not counted.
  - resume_i with halt_i==0: next state is RUN; the next cycle behaves as RUN.
  - resume_i while halt_i==1: stay in HALT.
- PC arithmetic is 32-bit and wraps mod 2^32; the block does not add internally, it uses fetch_pcPlus4_i.
- Counters saturate at all-ones.
- Sticky errors clear only on reset.
- Reset asserted mid-stall or mid-halt overrides everything at that edge.

Decomposition:
- Shared include (pipe_ctrl_defs.vh): state encodings BOOT/RUN/HALT (2-bit) and XLEN=32.
- One natural sub-module: sat_counter (parameter W; ports clk, rst_n, inc; output count), instantiated twice for stall_cnt and flush_cnt.
- FSM and output mux live in the top level.

Test Plan:
- Reset then boot: rst_n low 3 cycles, then high. pc_o=0 and flushes=1 for 2 more cycles; RUN follows; fetch PC sequence is 0,4,8,C.
- Stall: at fetch_pc=0x10, stall_i high 2 cycles. pc_o=0x10 both cycles, if_id_en_o=0, id_ex_flush_o=1; then 0x14; stall_cnt_o=2.
- Redirect plus stall in the same cycle, target 0x80. pc_o=0x80, both flushes=1, stall_cnt unchanged, flush_cnt_o=1; next pc_o=0x84.
- Misaligned redirect to 0x82. pc_o=0x82, misalign_err_o=1, halted_o=1 next cycle, PC frozen; resume_i returns to RUN while misalign_err_o stays 1.
- Watchdog: stall_i held 16 cycles. wdog_err_o=1 and halted_o=1 after the 16th stall cycle. With stall_i held only 15 cycles, no error.
- Reset during HALT: rst_n low 1 cycle. pc_o=RESET_PC, counters and errors cleared, BOOT re-entered.
